// File: rtl/ram16_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram16_access_ctrl_pkg
//   Shared types and helpers for the 16-bit-word RAM access controller.
//   - ram16_ctrl_state_e : sequencer states
//   - merge_half()       : byte-lane merge of one halfword
//   - is_partial_store() : true when either touched halfword is only half enabled
//   - PORT_I / PORT_D    : response-channel indices
// ---------------------------------------------------------------------------
package ram16_access_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR_LO,
    WR_HI
  } ram16_ctrl_state_e;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  // Byte lane b takes the new byte when be[b] is set, else keeps the old one.
  function automatic logic [15:0] merge_half(input logic [15:0] old_h,
                                             input logic [15:0] new_h,
                                             input logic [1:0]  be);
    logic [15:0] r;
    for (int b = 0; b < 2; b++) begin
      r[8*b +: 8] = be[b] ? new_h[8*b +: 8] : old_h[8*b +: 8];
    end
    return r;
  endfunction

  // A halfword with exactly one of its two byte enables set needs the old
  // contents first, so the whole store goes through the read-modify-write path.
  function automatic logic is_partial_store(input logic [3:0] we);
    return (we[1:0] == 2'b01) || (we[1:0] == 2'b10) ||
           (we[3:2] == 2'b01) || (we[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/ram16_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram16_access_ctrl_if
//   Bundles the core-side instruction/data handshakes and the RAM port.
//   modport slave  : the controller's view
//   modport master : the environment's view (core + RAM)
//   Instruction port : i_req_i, i_addr_i -> i_gnt_o, i_rvalid_o, i_rdata_o
//   Data port        : d_req_i, d_we_i, d_addr_i, d_wdata_i
//                      -> d_gnt_o, d_rvalid_o, d_rdata_o
//   RAM port         : mem_en_o, mem_we_o, mem_addr_o, mem_data_o
//                      <- mem_data_a_i (RAM[idx]), mem_data_b_i (RAM[idx+1])
// ---------------------------------------------------------------------------
interface ram16_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              i_req_i;
  logic [31:0]       i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [31:0]       i_rdata_o;

  logic              d_req_i;
  logic [3:0]        d_we_i;
  logic [31:0]       d_addr_i;
  logic [31:0]       d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [31:0]       d_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_a_i;
  logic [31:0]       mem_data_b_i;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_a_i, mem_data_b_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_a_i, mem_data_b_i
  );
endinterface

// File: rtl/ram16_rr_pick.sv
// ---------------------------------------------------------------------------
// ram16_rr_pick
//   Two-way requester selector (instruction vs data).
//   Configuration macro: RAM16_ARB_RR_EN
//     defined   : round-robin; on a tie the port not granted last wins. The
//                 last-grant flag resets to "instruction", so data wins the
//                 first tie. Ports clk, rst, en_i exist only in this build.
//     undefined : fixed priority, data over instruction; no state.
//   Ports:
//     clk, rst   clock / asynchronous active-high reset (RR build only)
//     en_i       a grant is actually issued this cycle (RR build only)
//     i_req_i    instruction request
//     d_req_i    data request
//     i_pick_o   instruction would be granted
//     d_pick_o   data would be granted
// ---------------------------------------------------------------------------
module ram16_rr_pick (
`ifdef RAM16_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic en_i,
`endif
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_pick_o,
  output logic d_pick_o
);

`ifdef RAM16_ARB_RR_EN
  logic last_was_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_was_d_q <= 1'b0;
    end else if (en_i && (i_req_i || d_req_i)) begin
      last_was_d_q <= d_pick_o;
    end
  end

  // Data wins unless instruction is also asking and data had the last turn.
  assign d_pick_o = d_req_i && (!i_req_i || !last_was_d_q);
`else
  assign d_pick_o = d_req_i;
`endif

  assign i_pick_o = i_req_i && !d_pick_o;

endmodule

// File: rtl/ram16_access_ctrl.sv
// ---------------------------------------------------------------------------
// ram16_access_ctrl
//   Sequencer/arbiter between the core's instruction and data ports and one
//   16-bit-word RAM with a single write port and a two-halfword read
//   (RAM[idx] and RAM[idx+1]). 32-bit stores become two halfword writes;
//   partially enabled halfwords are read-modify-written.
//   Parameter: MEM_WIDTH - RAM depth in halfwords (ADDR_W = $clog2(MEM_WIDTH)).
//   Configuration macro: RAM16_ARB_RR_EN selects round-robin arbitration
//   (see ram16_rr_pick); default is data-over-instruction priority.
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   ram16_access_ctrl_if.slave (instruction, data and RAM signals)
//   Word layout: word = {RAM[idx+1], RAM[idx]}, idx = addr[ADDR_W:1].
// ---------------------------------------------------------------------------
module ram16_access_ctrl
  import ram16_access_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  ram16_access_ctrl_if.slave   bus
);

  localparam int ADDR_W = $clog2(MEM_WIDTH);

  ram16_ctrl_state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              owner_q, owner_d;     // 1 = data port owns the operation
  logic              rvalid_q, rvalid_d;
  logic              from_rmw_q;           // previous cycle was RMW_RD
  logic [15:0]       old_hi_q;

  logic              idle;
  logic              i_pick, d_pick;
  logic              i_gnt, d_gnt, gnt_any;
  logic [31:0]       sel_addr;
  logic [3:0]        sel_we;
  logic [31:0]       sel_wdata;
  logic [15:0]       old_hi;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;

  // Grants are only meaningful in IDLE; holding them low during reset keeps
  // every output at 0 while rst is asserted.
  assign idle = (state_q == IDLE) && !rst;

`ifdef RAM16_ARB_RR_EN
  ram16_rr_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (idle),
    .i_req_i  (bus.i_req_i),
    .d_req_i  (bus.d_req_i),
    .i_pick_o (i_pick),
    .d_pick_o (d_pick)
  );
`else
  ram16_rr_pick u_pick (
    .i_req_i  (bus.i_req_i),
    .d_req_i  (bus.d_req_i),
    .i_pick_o (i_pick),
    .d_pick_o (d_pick)
  );
`endif

  assign i_gnt     = idle && i_pick;
  assign d_gnt     = idle && d_pick;
  assign gnt_any   = i_gnt || d_gnt;
  assign sel_addr  = d_gnt ? bus.d_addr_i : bus.i_addr_i;
  assign sel_we    = d_gnt ? bus.d_we_i : 4'b0000;
  assign sel_wdata = d_gnt ? bus.d_wdata_i : 32'h0;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = 32'h0;
    // Straight after RMW_RD the RAM output still holds the old hi half;
    // after a WR_LO it was captured into old_hi_q.
    old_hi   = from_rmw_q ? bus.mem_data_b_i[15:0] : old_hi_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          idx_d   = sel_addr[ADDR_W:1];
          we_d    = sel_we;
          wdata_d = sel_wdata;
          owner_d = d_gnt;
          if (sel_we == 4'b0000) begin
            state_d = RD;
          end else if (is_partial_store(sel_we)) begin
            state_d = RMW_RD;
          end else if (sel_we[1:0] == 2'b11) begin
            state_d = WR_LO;
          end else begin
            state_d = WR_HI;
          end
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = idx_q;
        state_d  = IDLE;
      end
      RMW_RD: begin
        mem_en   = 1'b1;
        mem_addr = idx_q;
        state_d  = (we_q[1:0] != 2'b00) ? WR_LO : WR_HI;
      end
      WR_LO: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = idx_q;
        mem_data = {16'h0, merge_half(bus.mem_data_a_i[15:0], wdata_q[15:0], we_q[1:0])};
        state_d  = (we_q[3:2] != 2'b00) ? WR_HI : IDLE;
      end
      WR_HI: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = idx_q + ADDR_W'(1);   // wraps modulo MEM_WIDTH
        mem_data = {16'h0, merge_half(old_hi, wdata_q[31:16], we_q[3:2])};
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion pulses in the first IDLE cycle after the last RAM operation.
  assign rvalid_d = (state_q != IDLE) && (state_d == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      we_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      owner_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      from_rmw_q <= 1'b0;
      old_hi_q   <= 16'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      rvalid_q   <= rvalid_d;
      from_rmw_q <= (state_q == RMW_RD);
      if (state_q == WR_LO) begin
        old_hi_q <= bus.mem_data_b_i[15:0];
      end
    end
  end

  // Response channels: index PORT_I / PORT_D. Read data is the RAM output
  // during the completion cycle; store completions return 0.
  logic [31:0] rd_word;
  logic [1:0]  rvalid_port;
  logic [31:0] rdata_port [2];

  assign rd_word = {bus.mem_data_b_i[15:0], bus.mem_data_a_i[15:0]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign rvalid_port[gi] = rvalid_q && (owner_q == 1'(gi));
    assign rdata_port[gi]  = (rvalid_port[gi] && (we_q == 4'b0000)) ? rd_word : 32'h0;
  end

  assign bus.i_gnt_o    = i_gnt;
  assign bus.d_gnt_o    = d_gnt;
  assign bus.i_rvalid_o = rvalid_port[PORT_I];
  assign bus.d_rvalid_o = rvalid_port[PORT_D];
  assign bus.i_rdata_o  = rdata_port[PORT_I];
  assign bus.d_rdata_o  = rdata_port[PORT_D];
  assign bus.mem_en_o   = mem_en;
  assign bus.mem_we_o   = mem_we;
  assign bus.mem_addr_o = mem_addr;
  assign bus.mem_data_o = mem_data;

  // Address bit 0, address bits above the RAM and the RAM's upper data bits
  // carry no information for this controller.
  logic unused_bits;
  assign unused_bits = ^{bus.i_addr_i[31:ADDR_W+1], bus.i_addr_i[0],
                         bus.d_addr_i[31:ADDR_W+1], bus.d_addr_i[0],
                         bus.mem_data_a_i[31:16], bus.mem_data_b_i[31:16]};

endmodule

// File: tb/tb_ram16_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram16_access_ctrl
//   Directed and randomized checks of ram16_access_ctrl against a
//   byte-addressed reference memory. Build with +define+RAM16_ARB_RR_EN to
//   exercise round-robin arbitration.
// ---------------------------------------------------------------------------
module tb_ram16_access_ctrl;

  localparam int MEM_WIDTH = 65536;
  localparam int ADDR_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram16_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ram16_access_ctrl #(.MEM_WIDTH(MEM_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: registered two-halfword read, one write port, plus a
  // preload port used only by the bench.
  logic [15:0] ram [MEM_WIDTH] = '{default: 16'h0};
  logic [31:0] ram_a_q = 32'h0;
  logic [31:0] ram_b_q = 32'h0;
  logic        pl_en   = 1'b0;
  logic [15:0] pl_idx  = 16'h0;
  logic [15:0] pl_data = 16'h0;
  logic [15:0] nxt_idx;

  assign nxt_idx          = bus.mem_addr_o + 16'd1;
  assign bus.mem_data_a_i = ram_a_q;
  assign bus.mem_data_b_i = ram_b_q;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_idx] <= pl_data;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        ram[bus.mem_addr_o] <= bus.mem_data_o[15:0];
      end else begin
        ram_a_q <= {16'h0, ram[bus.mem_addr_o]};
        ram_b_q <= {16'h0, ram[nxt_idx]};
      end
    end
  end

  // Log of RAM operation addresses during one transaction.
  logic [15:0] addr_log [$];
  always @(negedge clk) begin
    if (bus.mem_en_o === 1'b1) addr_log.push_back(bus.mem_addr_o);
  end

  // Reference memory, byte-level semantics.
  logic [15:0] ref_mem [MEM_WIDTH] = '{default: 16'h0};

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int idx;
    idx = int'(addr[16:1]);
    return {ref_mem[(idx + 1) % MEM_WIDTH], ref_mem[idx]};
  endfunction

  // Apply a store to the reference; ops = number of RAM cycles it needs
  // (one per touched halfword, plus one read if any halfword is partial).
  task automatic ref_store(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int ops);
    int idx, hw, touched;
    bit partial;
    logic [1:0]  be;
    logic [15:0] nv;
    idx = int'(addr[16:1]);
    touched = 0;
    partial = 1'b0;
    for (int h = 0; h < 2; h++) begin
      hw = (idx + h) % MEM_WIDTH;
      be = we[2*h +: 2];
      nv = wdata[16*h +: 16];
      if (be != 2'b00) touched++;
      if (be == 2'b01 || be == 2'b10) partial = 1'b1;
      for (int b = 0; b < 2; b++) begin
        if (be[b]) ref_mem[hw][8*b +: 8] = nv[8*b +: 8];
      end
    end
    ops = touched + (partial ? 1 : 0);
  endtask

  task automatic preload(input logic [15:0] idx, input logic [15:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  // One complete transaction on the chosen port, checked end to end.
  task automatic txn(input bit use_d, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int lat, ops, exp_lat, idx, hw;
    logic [31:0] exp_rd, obs_rd;
    logic        gnt;
    exp_rd = (we == 4'b0000) ? ref_word(addr) : 32'h0;
    if (we == 4'b0000) ops = 1;
    else ref_store(we, addr, wdata, ops);
    exp_lat = (we == 4'b0000) ? 2 : ops + 1;

    @(negedge clk);
    addr_log.delete();
    if (use_d) begin
      bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_addr_i = addr; bus.d_wdata_i = wdata;
    end else begin
      bus.i_req_i = 1'b1; bus.i_addr_i = addr;
    end
    #1;
    gnt = use_d ? bus.d_gnt_o : bus.i_gnt_o;
    chk("grant", {31'h0, gnt}, 32'h1);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    bus.i_req_i = 1'b0;
    lat = 1;
    while (!(use_d ? bus.d_rvalid_o : bus.i_rvalid_o) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    obs_rd = use_d ? bus.d_rdata_o : bus.i_rdata_o;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", obs_rd, exp_rd);
    chk("ram_ops", 32'(addr_log.size()), 32'(ops));
    if (we != 4'b0000) begin
      idx = int'(addr[16:1]);
      for (int h = 0; h < 2; h++) begin
        hw = (idx + h) % MEM_WIDTH;
        chk("ram_contents", {16'h0, ram[hw]}, {16'h0, ref_mem[hw]});
      end
    end
    @(negedge clk);
    chk("rvalid_pulse", {30'h0, bus.d_rvalid_o, bus.i_rvalid_o}, 32'h0);
    n_txn++;
    $display("txn %0d port=%s we=%b addr=%h wdata=%h lat=%0d rdata=%h",
             n_txn, use_d ? "D" : "I", we, addr, wdata, lat, obs_rd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.mem_en_o, bus.mem_we_o, bus.i_gnt_o, bus.d_gnt_o,
              bus.i_rvalid_o, bus.d_rvalid_o, 10'h0, bus.mem_addr_o}, 32'h0);
    chk({tag, "_data"}, bus.mem_data_o | bus.i_rdata_o | bus.d_rdata_o, 32'h0);
  endtask

  initial begin
    int cyc, g;
    logic [3:0]  pattern, exp_pattern;
    logic [3:0]  r_we;
    logic [15:0] r_idx;
    logic [31:0] r_addr;
    bit          r_d, saw_rvalid, both_gnt;

    bus.i_req_i = 1'b1;   // requesting during reset must not be granted
    bus.i_addr_i = 32'h0;
    bus.d_req_i = 1'b0; bus.d_we_i = 4'h0; bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    bus.i_req_i = 1'b0;
    rst = 1'b0;

    // 1: instruction read
    preload(16'h0010, 16'hBEEF);
    preload(16'h0011, 16'hDEAD);
    txn(1'b0, 4'b0000, 32'h0000_0020, 32'h0);
    chk("read_value", ref_word(32'h20), 32'hDEAD_BEEF);

    // 2: full-word store, then read back through the data port
    txn(1'b1, 4'b1111, 32'h0000_0040, 32'h1234_5678);
    txn(1'b1, 4'b0000, 32'h0000_0040, 32'h0);

    // 3: byte read-modify-write on the lo half
    preload(16'h0020, 16'hAAAA);
    txn(1'b1, 4'b0010, 32'h0000_0040, 32'h0000_5500);
    chk("rmw_lo", {16'h0, ram[16'h20]}, 32'h55AA);
    chk("rmw_hi_kept", {16'h0, ram[16'h21]}, 32'h1234);
    txn(1'b1, 4'b0100, 32'h0000_0041, 32'h00CC_0000);  // hi-only partial
    txn(1'b1, 4'b1110, 32'h0000_0040, 32'hA1B2_C3D4);  // both halves, lo partial

    // 5: wrap at the top of the RAM
    preload(16'hFFFF, 16'h1111);
    preload(16'h0000, 16'h2222);
    txn(1'b0, 4'b0000, 32'h0001_FFFE, 32'h0);
    chk("wrap_rd_addr", {16'h0, addr_log[0]}, 32'hFFFF);
    txn(1'b1, 4'b1111, 32'h0001_FFFE, 32'hABCD_0123);
    chk("wrap_wr_addr0", {16'h0, addr_log[0]}, 32'hFFFF);
    chk("wrap_wr_addr1", {16'h0, addr_log[1]}, 32'h0000);

    // 6: reset during WR_HI
    preload(16'h0180, 16'h1111);
    preload(16'h0181, 16'h2222);
    @(negedge clk);
    bus.d_req_i = 1'b1; bus.d_we_i = 4'b1111; bus.d_addr_i = 32'h0300; bus.d_wdata_i = 32'hBBBB_AAAA;
    @(negedge clk);
    bus.d_req_i = 1'b0;
    @(negedge clk);
    chk("in_wr_hi", {15'h0, bus.mem_we_o, bus.mem_addr_o}, {15'h0, 1'b1, 16'h0181});
    rst = 1'b1;
    bus.i_req_i = 1'b1;
    #1;
    chk_all_zero("reset_mid_store");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.i_req_i = 1'b0;
    ref_mem[16'h0180] = 16'hAAAA;   // lo written before reset, hi not
    saw_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      saw_rvalid |= bus.d_rvalid_o | bus.i_rvalid_o;
    end
    chk("no_rvalid_after_reset", {31'h0, saw_rvalid}, 32'h0);
    txn(1'b0, 4'b0000, 32'h0000_0300, 32'h0);

    // 4a: contention; data first, instruction granted in data's completion cycle
    @(negedge clk);
    bus.d_req_i = 1'b1; bus.d_we_i = 4'b0000; bus.d_addr_i = 32'h0040;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h0020;
    #1;
    chk("tie_gnt_d_i", {30'h0, bus.d_gnt_o, bus.i_gnt_o}, 32'h2);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    cyc = 1;
    while (!bus.d_rvalid_o && cyc < 20) begin @(negedge clk); cyc++; end
    #1;
    chk("tie_d_latency", 32'(cyc), 32'd2);
    chk("tie_d_rdata", bus.d_rdata_o, ref_word(32'h0040));
    chk("i_gnt_at_d_done", {31'h0, bus.i_gnt_o}, 32'h1);
    @(negedge clk);
    bus.i_req_i = 1'b0;
    cyc = 1;
    while (!bus.i_rvalid_o && cyc < 20) begin @(negedge clk); cyc++; end
    chk("tie_i_latency", 32'(cyc), 32'd2);
    chk("tie_i_rdata", bus.i_rdata_o, ref_word(32'h0020));
    $display("txn contention d-then-i done");

    // 4b: both held continuously; record the first four grants
    @(negedge clk);
    bus.d_req_i = 1'b1; bus.i_req_i = 1'b1;
    g = 0; cyc = 0; pattern = 4'b0000; both_gnt = 1'b0;
    while (g < 4 && cyc < 40) begin
      #1;
      both_gnt |= bus.d_gnt_o & bus.i_gnt_o;
      if (bus.d_gnt_o) begin pattern[g] = 1'b1; g++; end
      else if (bus.i_gnt_o) begin g++; end
      @(negedge clk);
      cyc++;
    end
    bus.d_req_i = 1'b0; bus.i_req_i = 1'b0;
`ifdef RAM16_ARB_RR_EN
    exp_pattern = 4'b0101;   // d, i, d, i
`else
    exp_pattern = 4'b1111;   // data always wins
`endif
    chk("grant_count", 32'(g), 32'd4);
    chk("grant_pattern", {28'h0, pattern}, {28'h0, exp_pattern});
    chk("single_grant", {31'h0, both_gnt}, 32'h0);
    $display("txn contention pattern=%b", pattern);
    repeat (5) @(negedge clk);

    // Randomized traffic over a small window plus the wrap point
    for (int t = 0; t < 40; t++) begin
      r_d    = 1'($urandom_range(0, 1));
      r_we   = r_d ? 4'($urandom_range(0, 15)) : 4'h0;
      r_idx  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0300 + 16'($urandom_range(0, 7));
      r_addr = {15'($urandom_range(0, 32767)), r_idx, 1'($urandom_range(0, 1))};
      txn(r_d, r_we, r_addr, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
